// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: word RAM with byte lanes plus a small MMIO page
// holding a GPIO port and a compare timer. Loads are combinational; stores
// commit on the rising clock edge.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned GPIO_W    = 8,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  input  logic              byte_enable,
  output logic [31:0]       readdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    OFF_GPIO_OUT = 3'd0,
    OFF_GPIO_IN  = 3'd1,
    OFF_TCNT     = 3'd2,
    OFF_TCMP     = 3'd3,
    OFF_TCTRL    = 3'd4
  } mmio_off_e;

  // Replace only the bytes selected by mask, keep the rest of the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [31:0]   mem [RAM_WORDS];

  logic [1:0]    lane;
  logic [31:0]   wmask;
  logic [31:0]   wlanes;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  mmio_off_e     off;

  logic [GPIO_W-1:0] gpio_meta, gpio_sync;
  logic [31:0]       tcnt, tcmp;
  logic              t_en, t_ar, t_flag;
  logic [PW-1:0]     presc;

  logic [GPIO_W-1:0] gpio_n;
  logic [31:0]       tcnt_n, tcmp_n;
  logic              t_en_n, t_ar_n, t_flag_n;
  logic [PW-1:0]     presc_n;
  logic              tick, flag_set, flag_clr;
  logic              wr_ram, wr_gpio, wr_tcnt, wr_tcmp, wr_tctrl;

  logic [31:0]   word_rd;
  logic [7:0]    byte_rd;

  assign lane     = addr[1:0];
  assign ram_hit  = (addr < RAM_BYTES);
  assign ram_idx  = addr[AW+1:2];
  assign mmio_hit = (addr[31:16] == 16'hFFFF) && (addr[15:5] == '0) && (addr[4:2] <= 3'd4);
  assign off      = mmio_off_e'(addr[4:2]);

  assign wr_ram   = memwrite && ram_hit;
  assign wr_gpio  = memwrite && mmio_hit && (off == OFF_GPIO_OUT);
  assign wr_tcnt  = memwrite && mmio_hit && (off == OFF_TCNT);
  assign wr_tcmp  = memwrite && mmio_hit && (off == OFF_TCMP);
  assign wr_tctrl = memwrite && mmio_hit && (off == OFF_TCTRL);

  assign timer_irq = t_flag;

  // Byte stores replicate the byte to every lane and enable only the addressed one.
  always_comb begin
    if (byte_enable) begin
      wmask  = 32'h0000_00FF << {lane, 3'b000};
      wlanes = {4{writedata[7:0]}};
    end else begin
      wmask  = '1;
      wlanes = writedata;
    end
  end

  // Combinational load path: select the word, then optionally sign-extend one lane.
  always_comb begin
    word_rd = '0;
    if (ram_hit) begin
      word_rd = mem[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_GPIO_OUT: word_rd = 32'(gpio_out);
        OFF_GPIO_IN:  word_rd = 32'(gpio_sync);
        OFF_TCNT:     word_rd = tcnt;
        OFF_TCMP:     word_rd = tcmp;
        OFF_TCTRL:    word_rd = {29'b0, t_flag, t_ar, t_en};
        default:      word_rd = '0;
      endcase
    end
    byte_rd  = word_rd[{lane, 3'b000} +: 8];
    readdata = byte_enable ? {{24{byte_rd[7]}}, byte_rd} : word_rd;
  end

  // RAM store port; RAM is deliberately not reset and survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_ram) mem[ram_idx] <= lane_merge(mem[ram_idx], wlanes, wmask);
  end

  // Next-state for timer and GPIO: hardware updates first, CPU writes override,
  // except the flag where a hardware set wins over a W1C clear.
  always_comb begin
    gpio_n   = gpio_out;
    tcnt_n   = tcnt;
    tcmp_n   = tcmp;
    t_en_n   = t_en;
    t_ar_n   = t_ar;
    flag_set = 1'b0;
    tick     = t_en && (presc == PMAX);

    if (t_en && !tick) presc_n = presc + PW'(1);
    else               presc_n = '0;

    if (tick) begin
      if (tcnt == tcmp) begin
        flag_set = 1'b1;
        if (t_ar) tcnt_n = '0;
        else      t_en_n = 1'b0;
      end else begin
        tcnt_n = tcnt + 32'd1;
      end
    end

    if (wr_gpio) gpio_n = GPIO_W'(lane_merge(32'(gpio_out), wlanes, wmask));
    if (wr_tcnt) tcnt_n = lane_merge(tcnt, wlanes, wmask);
    if (wr_tcmp) tcmp_n = lane_merge(tcmp, wlanes, wmask);
    if (wr_tctrl && wmask[0]) begin
      t_en_n = wlanes[0];
      t_ar_n = wlanes[1];
      if (wlanes[0] && !t_en) presc_n = '0;
    end

    flag_clr = wr_tctrl && wmask[2] && wlanes[2];
    t_flag_n = flag_set || (t_flag && !flag_clr);

    // A stopped timer always parks its prescaler at zero.
    if (!t_en_n) presc_n = '0;
  end

  // Register state with asynchronous reset, including the input synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
      gpio_out  <= '0;
      tcnt      <= '0;
      tcmp      <= '1;
      t_en      <= 1'b0;
      t_ar      <= 1'b0;
      t_flag    <= 1'b0;
      presc     <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      gpio_out  <= gpio_n;
      tcnt      <= tcnt_n;
      tcmp      <= tcmp_n;
      t_en      <= t_en_n;
      t_ar      <= t_ar_n;
      t_flag    <= t_flag_n;
      presc     <= presc_n;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: expected load values are queued when a
// load is driven and compared when the combinational result has settled.
module tb_dmem_mmio;

  localparam logic [31:0] A_GPO   = 32'hFFFF_0000;
  localparam logic [31:0] A_GPI   = 32'hFFFF_0004;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_TCTRL = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        byte_enable;
  logic [31:0] readdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] ram_m [64];
  int unsigned written_q [$];

  dmem_mmio #(.RAM_WORDS(64), .GPIO_W(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .byte_enable(byte_enable), .readdata(readdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Store committed on the next rising edge; returns 1ns after that edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b);
    @(negedge clk);
    memwrite = 1'b1; addr = a; writedata = d; byte_enable = b;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    if (a < 32'd256) begin
      if (b) ram_m[a[7:2]][{a[1:0], 3'b000} +: 8] = d[7:0];
      else   ram_m[a[7:2]] = d;
    end
  endtask

  // Load: queue expectation, drive address, compare after settling.
  task automatic rd(input string tag, input logic [31:0] a, input logic b, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    addr = a; byte_enable = b;
    #1;
    check(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0;
    byte_enable = 1'b0; gpio_in = '0;
    #2;
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_gpo", 32'(gpio_out), 32'd0);
    rd("rst_tcnt", A_TCNT, 1'b0, 32'd0);
    rd("rst_tcmp", A_TCMP, 1'b0, 32'hFFFF_FFFF);
    rd("rst_tctrl", A_TCTRL, 1'b0, 32'd0);
    #10 reset = 1'b0;

    // Word and byte RAM paths
    store(32'h10, 32'h1122_3344, 1'b0);
    rd("lw_10", 32'h10, 1'b0, 32'h1122_3344);
    rd("lw_12_align", 32'h12, 1'b0, 32'h1122_3344);
    store(32'h11, 32'h0000_00AB, 1'b1);
    rd("sb_merge", 32'h10, 1'b0, 32'h1122_AB44);
    rd("lb_11", 32'h11, 1'b1, 32'hFFFF_FFAB);
    rd("lb_10", 32'h10, 1'b1, 32'h0000_0044);
    rd("lb_13", 32'h13, 1'b1, 32'h0000_0011);

    // GPIO output with byte lanes and narrow-field masking
    store(A_GPO, 32'h1234_56A5, 1'b0);
    check("gpo_word", 32'(gpio_out), 32'h0000_00A5);
    rd("gpo_rd", A_GPO, 1'b0, 32'h0000_00A5);
    rd("gpo_lb", A_GPO, 1'b1, 32'hFFFF_FFA5);
    store(A_GPO + 32'd1, 32'h0000_0077, 1'b1);
    rd("gpo_lane1", A_GPO, 1'b0, 32'h0000_00A5);
    store(A_GPO, 32'h0000_003C, 1'b1);
    check("gpo_sb0", 32'(gpio_out), 32'h0000_003C);

    // Unmapped accesses
    store(32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
    rd("unmap_rd", 32'h8000_0000, 1'b0, 32'd0);
    rd("unmap_ram", 32'h10, 1'b0, 32'h1122_AB44);
    rd("unmap_gpo", A_GPO, 1'b0, 32'h0000_003C);
    rd("unmap_page", 32'hFFFF_0014, 1'b0, 32'd0);

    // GPIO input synchroniser
    gpio_in = 8'h5A;
    rd("gin_e0", A_GPI, 1'b0, 32'd0);
    @(posedge clk); #1;
    rd("gin_e1", A_GPI, 1'b0, 32'd0);
    @(posedge clk); #1;
    rd("gin_e2", A_GPI, 1'b0, 32'h0000_005A);
    store(A_GPI, 32'h0000_00FF, 1'b0);
    rd("gin_ro", A_GPI, 1'b0, 32'h0000_005A);

    // Timer with autoreload
    store(A_TCMP, 32'd3, 1'b0);
    store(A_TCTRL, 32'h3, 1'b0);
    rd("ar_tcnt0", A_TCNT, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("ar_irq_pre", 32'(timer_irq), 32'd0);
    rd("ar_tcnt3", A_TCNT, 1'b0, 32'd3);
    @(posedge clk); #1;
    check("ar_irq_4th", 32'(timer_irq), 32'd1);
    rd("ar_tcnt_rl", A_TCNT, 1'b0, 32'd0);
    rd("ar_tctrl", A_TCTRL, 1'b0, 32'h7);
    repeat (3) @(posedge clk);
    #1;
    rd("ar_p2_3", A_TCNT, 1'b0, 32'd3);
    @(posedge clk); #1;
    rd("ar_p2_0", A_TCNT, 1'b0, 32'd0);
    store(A_TCTRL, 32'h4, 1'b0);
    check("w1c_irq", 32'(timer_irq), 32'd0);
    rd("w1c_tctrl", A_TCTRL, 1'b0, 32'd0);
    rd("w1c_tcnt", A_TCNT, 1'b0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rd("frozen", A_TCNT, 1'b0, 32'd1);

    // CPU write to TCNT on a tick edge
    store(A_TCMP, 32'd1000, 1'b0);
    store(A_TCTRL, 32'h1, 1'b0);
    repeat (2) @(posedge clk);
    store(A_TCNT, 32'd100, 1'b0);
    rd("tcnt_wr_win", A_TCNT, 1'b0, 32'd100);
    @(posedge clk); #1;
    rd("tcnt_inc", A_TCNT, 1'b0, 32'd101);

    // W1C on the matching tick edge
    store(A_TCTRL, 32'h0, 1'b0);
    store(A_TCNT, 32'd0, 1'b0);
    store(A_TCMP, 32'd3, 1'b0);
    store(A_TCTRL, 32'h3, 1'b0);
    repeat (3) @(posedge clk);
    store(A_TCTRL, 32'h7, 1'b0);
    check("set_beats_clr", 32'(timer_irq), 32'd1);
    rd("set_beats_tcnt", A_TCNT, 1'b0, 32'd0);
    store(A_TCTRL, 32'h4, 1'b0);
    check("clr_irq2", 32'(timer_irq), 32'd0);

    // One-shot timer (autoreload=0)
    store(A_TCNT, 32'd0, 1'b0);
    store(A_TCTRL, 32'h1, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("os_irq", 32'(timer_irq), 32'd1);
    rd("os_tcnt", A_TCNT, 1'b0, 32'd3);
    rd("os_tctrl", A_TCTRL, 1'b0, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    rd("os_hold", A_TCNT, 1'b0, 32'd3);

    // CPU en write beats the hardware en clear
    store(A_TCTRL, 32'h4, 1'b0);
    store(A_TCNT, 32'd0, 1'b0);
    store(A_TCTRL, 32'h1, 1'b0);
    repeat (3) @(posedge clk);
    store(A_TCTRL, 32'h1, 1'b0);
    rd("en_wins", A_TCTRL, 1'b0, 32'h5);
    rd("en_wins_tcnt", A_TCNT, 1'b0, 32'd3);
    @(posedge clk); #1;
    rd("en_hw_clr", A_TCTRL, 1'b0, 32'h4);

    // Asynchronous reset mid-count
    store(A_TCNT, 32'd0, 1'b0);
    store(A_TCMP, 32'd2, 1'b0);
    store(A_TCTRL, 32'h3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rd("pre_rst_tcnt", A_TCNT, 1'b0, 32'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_irq", 32'(timer_irq), 32'd0);
    rd("mid_rst_tcnt", A_TCNT, 1'b0, 32'd0);
    rd("mid_rst_tctrl", A_TCTRL, 1'b0, 32'd0);
    rd("mid_rst_ram", 32'h10, 1'b0, 32'h1122_AB44);
    check("mid_rst_gpo", 32'(gpio_out), 32'd0);
    reset = 1'b0;

    // Random RAM traffic against a word model
    for (int i = 0; i < 12; i++) begin
      int unsigned idx;
      idx = $urandom_range(0, 63);
      store(idx * 4, $urandom, 1'b0);
      written_q.push_back(idx);
    end
    for (int i = 0; i < 8; i++) begin
      int unsigned idx;
      idx = written_q[$urandom_range(0, written_q.size() - 1)];
      store(idx * 4 + $urandom_range(0, 3), $urandom, 1'b1);
    end
    foreach (written_q[i]) begin
      int unsigned idx;
      int unsigned ln;
      logic [31:0] w;
      logic [7:0]  bv;
      idx = written_q[i];
      ln  = $urandom_range(0, 3);
      w   = ram_m[idx];
      bv  = w[ln*8 +: 8];
      rd("rand_lw", idx * 4, 1'b0, w);
      rd("rand_lb", idx * 4 + ln, 1'b1, {{24{bv[7]}}, bv});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
